// File: rtl/vec_dot_engine_if.sv
// rtl/vec_dot_engine_if.sv - dual-port vector memory read bus for vec_dot_engine
// Ports (signals):
//   addr_a, addr_b : read addresses for vectors A and B (ADDR_W)
//   rd_en          : read strobe; data returns exactly one cycle later
//   data_a, data_b : signed read data (WORD_SIZE)
// Modports: master = engine side, slave = memory side.
interface vec_dot_engine_if #(
    parameter int WORD_SIZE = 24,
    parameter int ADDR_W    = 9
);
    logic [ADDR_W-1:0]    addr_a;
    logic [ADDR_W-1:0]    addr_b;
    logic                 rd_en;
    logic [WORD_SIZE-1:0] data_a;
    logic [WORD_SIZE-1:0] data_b;

    modport master (
        output addr_a, addr_b, rd_en,
        input  data_a, data_b
    );

    modport slave (
        input  addr_a, addr_b, rd_en,
        output data_a, data_b
    );
endinterface

// File: rtl/vec_dot_engine.sv
// rtl/vec_dot_engine.sv - streaming dot-product / sum-of-squares engine
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, mode         : operation request (IDLE only); 0 = sum(a*b), 1 = sum(a*a)
//   base_a, base_b, len : vector start addresses and element count
//   Sum, busy, Done, ovf: signed result, operation in progress, completion pulse,
//                         sticky overflow
//   mem                 : memory read bus (vec_dot_engine_if.master)
// Macro VDOT_SAT_EN: when defined, Sum saturates on overflow; otherwise it wraps.
module vec_dot_engine #(
    parameter int WORD_SIZE = 24,
    parameter int ADDR_W    = 9,
    parameter int ACC_W     = 2*WORD_SIZE + ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       base_a,
    input  logic [ADDR_W-1:0]       base_b,
    input  logic [ADDR_W-1:0]       len,
    output logic signed [ACC_W-1:0] Sum,
    output logic                    busy,
    output logic                    Done,
    output logic                    ovf,
    vec_dot_engine_if.master        mem
);
    localparam int PW = 2*WORD_SIZE;
    // Adder width covers both the accumulator and a full product plus a guard
    // bit, so the exact sum is always available for overflow detection even
    // when ACC_W is narrower than a product.
    localparam int EW = ((ACC_W > PW) ? ACC_W : PW) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t            state;
    logic              mode_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx;
    logic              dv;      // read data on the bus this cycle is valid

    logic signed [PW-1:0]    ext_a;
    logic signed [PW-1:0]    ext_b;
    logic signed [PW-1:0]    prod;
    logic signed [EW-1:0]    tot;
    logic [EW-ACC_W:0]       hi;
    logic                    acc_ovf;
    logic [ACC_W-1:0]        acc_next;

    always_comb begin
        ext_a = {{WORD_SIZE{mem.data_a[WORD_SIZE-1]}}, mem.data_a};
        ext_b = mode_q ? ext_a : {{WORD_SIZE{mem.data_b[WORD_SIZE-1]}}, mem.data_b};
        prod  = ext_a * ext_b;
        tot   = {{(EW-ACC_W){Sum[ACC_W-1]}}, Sum} + {{(EW-PW){prod[PW-1]}}, prod};
        // The exact sum fits ACC_W only if all bits from the ACC_W sign bit up agree.
        hi      = tot[EW-1:ACC_W-1];
        acc_ovf = ~((&hi) | ~(|hi));
`ifdef VDOT_SAT_EN
        if (acc_ovf)
            acc_next = tot[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_next = tot[ACC_W-1:0];
`else
        acc_next = tot[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            idx        <= '0;
            dv         <= 1'b0;
            Sum        <= '0;
            busy       <= 1'b0;
            Done       <= 1'b0;
            ovf        <= 1'b0;
            mem.addr_a <= '0;
            mem.addr_b <= '0;
            mem.rd_en  <= 1'b0;
        end else begin
            Done <= 1'b0;
            dv   <= mem.rd_en;
            if (dv) begin
                Sum <= acc_next;
                if (acc_ovf)
                    ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        len_q      <= len;
                        idx        <= '0;
                        Sum        <= '0;
                        ovf        <= 1'b0;
                        busy       <= 1'b1;
                        mem.addr_a <= base_a;
                        mem.addr_b <= base_b;
                        if (len == '0) begin
                            state <= FIN;
                            Done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            mem.rd_en <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (idx == len_q - ADDR_W'(1)) begin
                        state     <= DRAIN;
                        mem.rd_en <= 1'b0;
                    end else begin
                        idx        <= idx + 1'b1;
                        mem.addr_a <= mem.addr_a + 1'b1;
                        if (!mode_q)
                            mem.addr_b <= mem.addr_b + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last element's data is on the bus now and is added at this edge.
                    state <= FIN;
                    Done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_dot_engine.sv
// tb/tb_vec_dot_engine.sv - randomized self-checking bench for vec_dot_engine
module tb_vec_dot_engine;
    logic              clk = 1'b0;
    logic              rst;
    logic              start, start16, mode;
    logic [8:0]        base_a, base_b, len;
    logic signed [56:0] sum;
    logic signed [15:0] sum16;
    logic              busy, done, ovf, busy16, done16, ovf16;

    int checks = 0;
    int failures = 0;

    logic [23:0] mem_a [512];
    logic [23:0] mem_b [512];

    int   last_rd_cnt, last_done_c;
    int   addr_log [16];

    vec_dot_engine_if #(.WORD_SIZE(24), .ADDR_W(9)) mem ();
    vec_dot_engine_if #(.WORD_SIZE(24), .ADDR_W(9)) mem16 ();

    vec_dot_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_a(base_a), .base_b(base_b), .len(len),
        .Sum(sum), .busy(busy), .Done(done), .ovf(ovf), .mem(mem)
    );

    vec_dot_engine #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode),
        .base_a(base_a), .base_b(base_b), .len(len),
        .Sum(sum16), .busy(busy16), .Done(done16), .ovf(ovf16), .mem(mem16)
    );

    always #5 clk = ~clk;

    // Memory: registered read, one-cycle latency; junk on the bus when not reading.
    always @(posedge clk) begin
        if (mem.rd_en) begin
            mem.data_a <= mem_a[mem.addr_a];
            mem.data_b <= mem_b[mem.addr_b];
        end else begin
            mem.data_a <= 24'($urandom);
            mem.data_b <= 24'($urandom);
        end
        if (mem16.rd_en) begin
            mem16.data_a <= mem_a[mem16.addr_a];
            mem16.data_b <= mem_b[mem16.addr_b];
        end else begin
            mem16.data_a <= 24'($urandom);
            mem16.data_b <= 24'($urandom);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Reference: exact integer accumulation, then wrap or clamp to accw bits.
    function automatic longint model(input int accw, input bit m, input int ba, input int bb,
                                     input int n, output bit ov);
        longint s, a, b, mx, mn, u;
        s  = 0;
        ov = 1'b0;
        mx = (longint'(1) <<< (accw-1)) - 1;
        mn = -mx - 1;
        for (int i = 0; i < n; i++) begin
            a = $signed(mem_a[(ba+i)%512]);
            b = m ? a : $signed(mem_b[(bb+i)%512]);
            s = s + a*b;
            if (s > mx || s < mn) begin
                ov = 1'b1;
`ifdef VDOT_SAT_EN
                s = (s > mx) ? mx : mn;
`else
                u = s & ((longint'(1) <<< accw) - 1);
                s = (u > mx) ? u - (longint'(1) <<< accw) : u;
`endif
            end
        end
        return s;
    endfunction

    // Caller is at a negedge. Drives one operation and compares every cycle.
    task automatic run_op(input bit m, input int ba, input int bb, input int n);
        longint es, sd;
        bit     eov;
        int     dc, idx;
        es = model(57, m, ba, bb, n, eov);
        start = 1'b1; mode = m; base_a = 9'(ba); base_b = 9'(bb); len = 9'(n);
        dc = (n == 0) ? 1 : n + 2;
        last_rd_cnt = 0;
        last_done_c = 0;
        for (int c = 1; c <= dc; c++) begin
            @(negedge clk);
            idx = (c <= n) ? c - 1 : n - 1;
            chk("rd_en", mem.rd_en, c <= n);
            if (mem.rd_en === 1'b1) begin
                if (last_rd_cnt < 16) addr_log[last_rd_cnt] = int'(mem.addr_a);
                last_rd_cnt++;
            end
            if (n > 0) begin
                chk("addr_a", mem.addr_a, (ba + idx) % 512);
                chk("addr_b", mem.addr_b, m ? bb : (bb + idx) % 512);
            end
            chk("busy", busy, 1'b1);
            chk("done", done, c == dc);
            if (done === 1'b1 && last_done_c == 0) last_done_c = c;
            if (c == dc) begin
                sd = sum;
                chk("sum", sd, es);
                chk("ovf", ovf, eov);
            end
            // Requests while busy or in FIN must be ignored.
            start  = 1'($urandom);
            mode   = 1'($urandom);
            base_a = 9'($urandom);
            base_b = 9'($urandom);
            len    = 9'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        sd = sum;
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_rd_en", mem.rd_en, 1'b0);
        chk("hold_sum", sd, es);
        chk("hold_ovf", ovf, eov);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint sd, e16;
        bit     eov16;
        int     dcyc;
        rst = 1'b0; start = 1'b0; start16 = 1'b0; mode = 1'b0;
        base_a = '0; base_b = '0; len = '0;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 24'($urandom);
            mem_b[i] = 24'($urandom);
        end
        repeat (2) @(negedge clk);
        sd = sum;
        chk("rst_sum", sd, 0);
        chk("rst_addr_a", mem.addr_a, 0);
        chk("rst_addr_b", mem.addr_b, 0);
        chk("rst_rd_en", mem.rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;

        // Dot product 1..4 . 5..8, started at the first edge after reset release.
        for (int i = 0; i < 4; i++) begin
            mem_a[10+i] = 24'(i + 1);
            mem_b[100+i] = 24'(i + 5);
        end
        run_op(1'b0, 10, 100, 4);
        sd = sum;
        chk("lit_dot_sum", sd, 70);
        chk("lit_dot_done_cyc", last_done_c, 6);
        chk("lit_dot_rd_cnt", last_rd_cnt, 4);

        // Sum of squares -3,4,-5.
        mem_a[300] = -24'sd3; mem_a[301] = 24'sd4; mem_a[302] = -24'sd5;
        run_op(1'b1, 300, 77, 3);
        sd = sum;
        chk("lit_sq_sum", sd, 50);

        // Zero length.
        run_op(1'b0, 5, 6, 0);
        sd = sum;
        chk("lit_len0_sum", sd, 0);
        chk("lit_len0_done_cyc", last_done_c, 1);
        chk("lit_len0_rd_cnt", last_rd_cnt, 0);

        // Address wrap.
        run_op(1'b0, 510, 20, 4);
        chk("lit_wrap0", addr_log[0], 510);
        chk("lit_wrap1", addr_log[1], 511);
        chk("lit_wrap2", addr_log[2], 0);
        chk("lit_wrap3", addr_log[3], 1);

        // Reset in the second issue cycle of a len=8 operation.
        start = 1'b1; mode = 1'b0; base_a = 9'd40; base_b = 9'd80; len = 9'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        sd = sum;
        chk("mid_rst_sum", sd, 0);
        chk("mid_rst_addr_a", mem.addr_a, 0);
        chk("mid_rst_addr_b", mem.addr_b, 0);
        chk("mid_rst_rd_en", mem.rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ovf", ovf, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", done, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
        end
        run_op(1'b0, 60, 90, 2);

        // Randomized operations.
        for (int k = 0; k < 25; k++)
            run_op(1'($urandom), $urandom_range(0, 511), $urandom_range(0, 511),
                   $urandom_range(0, 12));

        // Narrow accumulator overflow.
        mem_a[200] = 24'd200; mem_a[201] = 24'd200; mem_a[202] = 24'd200;
        e16 = model(16, 1'b1, 200, 0, 3, eov16);
        start16 = 1'b1; mode = 1'b1; base_a = 9'd200; base_b = 9'd0; len = 9'd3;
        dcyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16 === 1'b1 && dcyc == 0) dcyc = c;
        end
        chk("ovf16_done_cyc", dcyc, 5);
        chk("ovf16_flag", ovf16, 1'b1);
        chk("ovf16_model_flag", 64'(eov16), 1);
        sd = sum16;
        chk("ovf16_sum_model", sd, e16);
`ifdef VDOT_SAT_EN
        chk("ovf16_sum_lit", $unsigned(sum16), 32767);
`else
        chk("ovf16_sum_lit", $unsigned(sum16), 54464);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vec_dot_engine.md
VEC_DOT_ENGINE -- requirements
Module: vec_dot_engine

Interface
REQ-001 Parameter WORD_SIZE, default 24: element width, signed two's complement.
REQ-002 Parameter ADDR_W, default 9: memory address and length width.
REQ-003 Parameter ACC_W, default 2*WORD_SIZE+ADDR_W: accumulator and Sum width.
REQ-004 clk  in  1  single clock, rising-edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request a new operation, sampled in IDLE only.
REQ-007 mode  in  1  0 = dot product sum(a[i]*b[i]); 1 = sum of squares sum(a[i]*a[i]).
REQ-008 base_a, base_b  in  ADDR_W each  start addresses of vectors A and B.
REQ-009 len  in  ADDR_W  element count.
REQ-010 addr_a, addr_b  out  ADDR_W each  memory read addresses.
REQ-011 rd_en  out  1  memory read strobe.
REQ-012 data_a, data_b  in  WORD_SIZE each  read data, valid exactly one cycle after the address is presented with rd_en=1.
REQ-013 Sum  out  ACC_W  result, signed.
REQ-014 busy  out  1  high from the cycle after start is accepted until Done.
REQ-015 Done  out  1  one-cycle completion pulse.
REQ-016 ovf  out  1  sticky overflow flag for the current operation.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, FIN; FIN returns to IDLE unconditionally.
REQ-018 IDLE with start=1 at an edge: latch mode, base_a, base_b and len; clear Sum and ovf; go to ISSUE, or go to FIN if len=0.
REQ-019 start while busy or in FIN: ignored, with no effect on latched operands.
REQ-020 ISSUE: rd_en=1 for exactly len cycles; cycle k presents addr_a=base_a+k and addr_b=base_b+k (k=0..len-1), wrapping modulo 2^ADDR_W.
REQ-021 After the last issue cycle: go to DRAIN for one cycle (rd_en=0), then to FIN.
REQ-022 Each returned element: product = data_a*data_b (mode 0) or data_a*data_a (mode 1), sign-extended to ACC_W and added to Sum at the edge ending the data cycle.
REQ-023 Mode 1: data_b ignored; addr_b holds base_b.
REQ-024 FIN: Done=1 for one cycle; Sum holds its final value.
REQ-025 Latency: Done asserts in cycle len+2 after the start-accept edge (len>=1), or in cycle 1 for len=0 with Sum=0.
REQ-026 Sum and ovf hold after Done until the next accepted start.
REQ-027 IDLE: rd_en=0; addr_a and addr_b hold their last values.
REQ-028 Overflow: a signed ACC_W overflow on any add sets ovf, which stays set until the next start.

Reset
REQ-029 rst=0: immediately force state IDLE and set Sum=0, addr_a=0, addr_b=0, rd_en=0, busy=0, Done=0, ovf=0, independent of clk.
REQ-030 Reset during ISSUE or DRAIN: abandon the operation with no Done pulse; in-flight read data is discarded.
REQ-031 First start is accepted at the first rising edge after rst deasserts.

Configuration
REQ-032 Macro VDOT_SAT_EN defined: on overflow, Sum saturates to the signed ACC_W max or min and remains saturated in that direction for further same-sign adds; ovf is set.
REQ-033 Macro VDOT_SAT_EN undefined: Sum wraps modulo 2^ACC_W; ovf is still set.

Verification
REQ-034 mode=0, len=4, A=1,2,3,4, B=5,6,7,8 -> Sum=70, Done in cycle 6 after start edge, rd_en high for 4 cycles.
REQ-035 mode=1, len=3, A=-3,4,-5 -> Sum=50; addr_b constant at base_b.
REQ-036 len=0, start -> Done in cycle 1, Sum=0, rd_en never asserted.
REQ-037 base_a=510, len=4 (ADDR_W=9) -> addr_a sequence 510,511,0,1.
REQ-038 rst pulled low in the 2nd ISSUE cycle of a len=8 operation -> all outputs 0 immediately, no Done; a subsequent len=2 operation returns the correct result.
REQ-039 ACC_W overridden to 16, mode=1, len=3, A=200,200,200 -> ovf=1; Sum=32767 with VDOT_SAT_EN defined, 54464 (wrapped bit pattern) without it.
